// File: rtl/pim_mem_arbiter_pkg.sv
// Shared definitions for the CPU/PIM data-RAM arbiter.
//   - owner encodings carried in the read-return tag pipe
//   - CPU-side request FSM states
//   - read-return tag type and the legal RAM read-latency range
package pim_mem_arbiter_pkg;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_PIM = 1'b1;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 3;

  typedef enum logic [1:0] {
    C_IDLE     = 2'd0,
    C_WAIT     = 2'd1,
    C_INFLIGHT = 2'd2
  } cpu_state_e;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

  function automatic bit rd_lat_legal(input int unsigned lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/pim_mem_arbiter_rd_tag_pipe.sv
// Read-return tag pipe: a Depth-deep shift register of {valid, owner} tags.
// A tag written at the issue cycle appears on tag_o exactly Depth cycles later,
// aligned with the RAM read data.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset, clears all tags
//   tag_i  : tag for the access issued this cycle
//   tag_o  : tag matching the RAM data returning this cycle
module pim_mem_arbiter_rd_tag_pipe
  import pim_mem_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t [Depth-1:0] pipe_q;
  rd_tag_t [Depth-1:0] pipe_d;

  if (Depth > 1) begin : g_shift
    assign pipe_d = {pipe_q[Depth-2:0], tag_i};
  end else begin : g_single
    assign pipe_d = tag_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_o = pipe_q[Depth-1];

endmodule

// File: rtl/pim_mem_arbiter.sv
// Shares a single-port data RAM between the FemtoRV32 memory port and the PIM
// engine. CPU strobes are one cycle wide and are captured until issued; PIM
// requests are level-held until pim_gnt. One RAM access issues per cycle, with
// strict alternation under contention, and read data is steered back to its
// owner via a tag pipe matching the RAM read latency.
//   CLK, RESET            : clock, asynchronous active-low reset
//   cpu_*                 : FemtoRV32 port (addr/wdata/wmask/rstrb in, rdata/rbusy/wbusy out)
//   pim_*                 : PIM port (req/we/addr/wdata/wmask in, gnt/rvalid/rdata out)
//   ram_*                 : RAM port (en/we/addr/wdata out, rdata in after RD_LAT cycles)
module pim_mem_arbiter
  import pim_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wmask,
  input  logic                cpu_rstrb,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_rbusy,
  output logic                cpu_wbusy,
  input  logic                pim_req,
  input  logic                pim_we,
  input  logic [ADDR_W-1:0]   pim_addr,
  input  logic [DATA_W-1:0]   pim_wdata,
  input  logic [DATA_W/8-1:0] pim_wmask,
  output logic                pim_gnt,
  output logic                pim_rvalid,
  output logic [DATA_W-1:0]   pim_rdata,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int unsigned MaskW = DATA_W / 8;

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("pim_mem_arbiter: RD_LAT must be in 1..3");
  end

  cpu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [MaskW-1:0]  req_wmask_q, req_wmask_d;
  logic              req_rd_q, req_rd_d;
  logic              last_owner_q, last_owner_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  logic              cpu_strobe, cpu_elig, cpu_win, pim_win, cpu_rd;
  logic [ADDR_W-1:0] cpu_addr_eff, sel_addr;
  logic [DATA_W-1:0] cpu_wdata_eff;
  logic [MaskW-1:0]  cpu_wmask_eff;
  logic              cpu_ret, pim_ret;
  rd_tag_t           tag_in, tag_out;
  logic [1:0]        unused_addr_lsbs;

  // In C_IDLE the live strobe is eligible the same cycle; in C_WAIT the
  // captured copy is presented instead.
  always_comb begin
    cpu_strobe    = (state_q == C_IDLE) && (cpu_rstrb || (|cpu_wmask));
    cpu_elig      = cpu_strobe || (state_q == C_WAIT);
    cpu_rd        = (state_q == C_WAIT) ? req_rd_q    : ~(|cpu_wmask);
    cpu_addr_eff  = (state_q == C_WAIT) ? req_addr_q  : cpu_addr;
    cpu_wdata_eff = (state_q == C_WAIT) ? req_wdata_q : cpu_wdata;
    cpu_wmask_eff = (state_q == C_WAIT) ? req_wmask_q : cpu_wmask;
  end

  // Issue is gated by RESET so every output is quiet while reset is held.
  always_comb begin
    cpu_win = RESET && cpu_elig && (!pim_req || (last_owner_q == OWNER_PIM));
    pim_win = RESET && pim_req && !(cpu_elig && (last_owner_q == OWNER_PIM));
  end

  always_comb begin
    tag_in.valid = (cpu_win && cpu_rd) || (pim_win && !pim_we);
    tag_in.owner = cpu_win ? OWNER_CPU : OWNER_PIM;
  end

  pim_mem_arbiter_rd_tag_pipe #(
    .Depth (RD_LAT)
  ) u_rd_tag_pipe (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .tag_i  (tag_in),
    .tag_o  (tag_out)
  );

  always_comb begin
    cpu_ret = tag_out.valid && (tag_out.owner == OWNER_CPU);
    pim_ret = tag_out.valid && (tag_out.owner == OWNER_PIM);
  end

  // RAM port and master-side outputs.
  always_comb begin
    sel_addr         = cpu_win ? cpu_addr_eff : pim_addr;
    unused_addr_lsbs = sel_addr[1:0];
    ram_en           = cpu_win || pim_win;
    ram_we           = '0;
    ram_addr         = '0;
    ram_wdata        = '0;
    if (cpu_win) begin
      ram_we    = cpu_wmask_eff;
      ram_addr  = {2'b00, sel_addr[ADDR_W-1:2]};
      ram_wdata = cpu_wdata_eff;
    end else if (pim_win) begin
      ram_we    = pim_we ? pim_wmask : '0;
      ram_addr  = {2'b00, sel_addr[ADDR_W-1:2]};
      ram_wdata = pim_wdata;
    end
    pim_gnt    = pim_win;
    pim_rvalid = pim_ret;
    pim_rdata  = pim_ret ? ram_rdata : '0;
    // CPU sees return data in the return cycle itself, then the held copy.
    cpu_rdata  = cpu_ret ? ram_rdata : cpu_rdata_q;
    cpu_rbusy  = ((state_q == C_WAIT) && req_rd_q) || ((state_q == C_INFLIGHT) && !cpu_ret);
    cpu_wbusy  = (state_q == C_WAIT) && !req_rd_q;
  end

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_wmask_d  = req_wmask_q;
    req_rd_d     = req_rd_q;
    cpu_rdata_d  = cpu_rdata;
    last_owner_d = cpu_win ? OWNER_CPU : (pim_win ? OWNER_PIM : last_owner_q);
    unique case (state_q)
      C_IDLE: begin
        if (cpu_strobe) begin
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          req_wmask_d = cpu_wmask;
          req_rd_d    = cpu_rd;
          if (cpu_win) begin
            state_d = cpu_rd ? C_INFLIGHT : C_IDLE;
          end else begin
            state_d = C_WAIT;
          end
        end
      end
      C_WAIT: begin
        if (cpu_win) begin
          state_d = req_rd_q ? C_INFLIGHT : C_IDLE;
        end
      end
      C_INFLIGHT: begin
        if (cpu_ret) begin
          state_d = C_IDLE;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= C_IDLE;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_wmask_q  <= '0;
      req_rd_q     <= 1'b0;
      last_owner_q <= OWNER_PIM;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_wmask_q  <= req_wmask_d;
      req_rd_q     <= req_rd_d;
      last_owner_q <= last_owner_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

endmodule
